// File: rtl/fp_mul_arb_pkg.sv
// Shared types and constants for the single-precision multiplier arbiter.
// The operation counters exist only when FP_MUL_ARB_STATS_EN is defined.
package fp_mul_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEND_A = 3'd1,
        SEND_B = 3'd2,
        WAIT_Z = 3'd3,
        RETURN = 3'd4
    } state_t;

    localparam logic [31:0] QNAN    = 32'hFFC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam int          STAT_W  = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/fp_mul_arbiter_if.sv
// Requester and multiplier handshake bundle for fp_mul_arbiter.
// The slave modport is the arbiter view; master is the clients-plus-multiplier view.
interface fp_mul_arbiter_if #(parameter int NUM_REQ = 4);

    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ-1:0]    req_stb;
    logic [NUM_REQ-1:0]    req_ack;
    logic [31:0]           rsp_z;
    logic [NUM_REQ-1:0]    rsp_stb;
    logic [NUM_REQ-1:0]    rsp_ack;
    logic [31:0]           mul_a;
    logic                  mul_a_stb;
    logic                  mul_a_ack;
    logic [31:0]           mul_b;
    logic                  mul_b_stb;
    logic                  mul_b_ack;
    logic [31:0]           mul_z;
    logic                  mul_z_stb;
    logic                  mul_z_ack;

    modport slave (
        input  req_a, req_b, req_stb, rsp_ack,
        input  mul_a_ack, mul_b_ack, mul_z, mul_z_stb,
        output req_ack, rsp_z, rsp_stb,
        output mul_a, mul_a_stb, mul_b, mul_b_stb, mul_z_ack
    );

    modport master (
        output req_a, req_b, req_stb, rsp_ack,
        output mul_a_ack, mul_b_ack, mul_z, mul_z_stb,
        input  req_ack, rsp_z, rsp_stb,
        input  mul_a, mul_a_stb, mul_b, mul_b_stb, mul_z_ack
    );

endinterface

// File: rtl/fp_mul_arbiter_rr.sv
// Combinational round-robin picker: first set request after the pointer, wrapping.
// Kept generic so other shared-unit schedulers can reuse it.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int GNT_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [GNT_W-1:0]   i_ptr,
    output logic [GNT_W-1:0]   o_gnt,
    output logic               o_vld
);

    int w_idx;

    // Walk farthest-first so the nearest request after the pointer wins.
    always_comb begin
        o_gnt = '0;
        o_vld = 1'b0;
        w_idx = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = (int'(i_ptr) + k) % NUM_REQ;
            if (i_req[w_idx]) begin
                o_gnt = GNT_W'(w_idx);
                o_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin sharing of one stb/ack single-precision multiplier among NUM_REQ clients.
// Define FP_MUL_ARB_STATS_EN to add per-requester saturating op counters (op_count, stats_clr).
module fp_mul_arbiter
    import fp_mul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GNT_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    fp_mul_arbiter_if.slave    bus,
    output logic               busy,
    output logic [GNT_W-1:0]   gnt_id
`ifdef FP_MUL_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0] op_count,
    input  logic                      stats_clr
`endif
);

    state_t             r_state;
    logic [GNT_W-1:0]   r_gnt;
    logic [GNT_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] r_req_ack;
    logic [NUM_REQ-1:0] r_rsp_stb;
    logic [31:0]        r_rsp_z;
    logic [31:0]        r_mul_a;
    logic [31:0]        r_mul_b;
    logic [31:0]        r_op_b;
    logic               r_mul_a_stb;
    logic               r_mul_b_stb;
    logic               r_mul_z_ack;
    logic               r_busy;

    logic [GNT_W-1:0]   w_gnt;
    logic               w_gnt_vld;
    logic [NUM_REQ-1:0] w_gnt_oh;
    logic [NUM_REQ-1:0] w_cur_oh;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .GNT_W   (GNT_W)
    ) u_rr (
        .i_req (bus.req_stb),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_vld (w_gnt_vld)
    );

    assign w_gnt_oh = NUM_REQ'(1) << w_gnt;
    assign w_cur_oh = NUM_REQ'(1) << r_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_ptr       <= GNT_W'(NUM_REQ - 1);
            r_req_ack   <= '0;
            r_rsp_stb   <= '0;
            r_rsp_z     <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_op_b      <= '0;
            r_mul_a_stb <= 1'b0;
            r_mul_b_stb <= 1'b0;
            r_mul_z_ack <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_req_ack <= '0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_vld) begin
                        r_gnt       <= w_gnt;
                        r_req_ack   <= w_gnt_oh;
                        r_mul_a     <= bus.req_a[int'(w_gnt)*32 +: 32];
                        r_op_b      <= bus.req_b[int'(w_gnt)*32 +: 32];
                        r_mul_a_stb <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= SEND_A;
                    end
                end
                SEND_A: begin
                    if (r_mul_a_stb && bus.mul_a_ack) begin
                        r_mul_a_stb <= 1'b0;
                        r_mul_b     <= r_op_b;
                        r_mul_b_stb <= 1'b1;
                        r_state     <= SEND_B;
                    end
                end
                SEND_B: begin
                    if (r_mul_b_stb && bus.mul_b_ack) begin
                        r_mul_b_stb <= 1'b0;
                        r_mul_z_ack <= 1'b1;
                        r_state     <= WAIT_Z;
                    end
                end
                WAIT_Z: begin
                    if (r_mul_z_ack && bus.mul_z_stb) begin
                        r_rsp_z     <= bus.mul_z;
                        r_mul_z_ack <= 1'b0;
                        r_rsp_stb   <= w_cur_oh;
                        r_state     <= RETURN;
                    end
                end
                RETURN: begin
                    // Only the granted requester's accept closes the operation.
                    if (bus.rsp_ack[r_gnt]) begin
                        r_rsp_stb <= '0;
                        r_ptr     <= r_gnt;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ack   = r_req_ack;
    assign bus.rsp_stb   = r_rsp_stb;
    assign bus.rsp_z     = r_rsp_z;
    assign bus.mul_a     = r_mul_a;
    assign bus.mul_a_stb = r_mul_a_stb;
    assign bus.mul_b     = r_mul_b;
    assign bus.mul_b_stb = r_mul_b_stb;
    assign bus.mul_z_ack = r_mul_z_ack;
    assign busy          = r_busy;
    assign gnt_id        = r_gnt;

`ifdef FP_MUL_ARB_STATS_EN
    logic [NUM_REQ*STAT_W-1:0] r_op_count;

    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            r_op_count <= '0;
        end else if (r_rsp_stb[r_gnt] && bus.rsp_ack[r_gnt]) begin
            r_op_count[int'(r_gnt)*STAT_W +: STAT_W] <=
                sat_inc(r_op_count[int'(r_gnt)*STAT_W +: STAT_W]);
        end
    end

    assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Scoreboard bench for fp_mul_arbiter: directed requests, behavioural multiplier, response monitor.
// Optional counter checks build when FP_MUL_ARB_STATS_EN is defined.
module tb_fp_mul_arbiter;
    import fp_mul_arb_pkg::*;

    localparam int N = 4;

    localparam logic [31:0] F_0P5 = 32'h3F00_0000;
    localparam logic [31:0] F_1P0 = 32'h3F80_0000;
    localparam logic [31:0] F_1P5 = 32'h3FC0_0000;
    localparam logic [31:0] F_2P0 = 32'h4000_0000;
    localparam logic [31:0] F_3P0 = 32'h4040_0000;
    localparam logic [31:0] F_2P25 = 32'h4010_0000;
    localparam logic [31:0] F_6P0 = 32'h40C0_0000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic [1:0] gnt_id;

    always #5 clk = ~clk;

    fp_mul_arbiter_if #(.NUM_REQ(N)) bus ();

`ifdef FP_MUL_ARB_STATS_EN
    logic [N*STAT_W-1:0] op_count;
    logic                stats_clr = 1'b0;
`endif

    fp_mul_arbiter #(
        .NUM_REQ (N),
        .GNT_W   (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .busy   (busy),
        .gnt_id (gnt_id)
`ifdef FP_MUL_ARB_STATS_EN
        ,
        .op_count  (op_count),
        .stats_clr (stats_clr)
`endif
    );

    logic [31:0]  ta  [N];
    logic [31:0]  tbv [N];
    logic [N-1:0] tstb = '0;
    logic [N-1:0] hold = '0;
    logic [N-1:0] junk = '0;

    for (genvar gi = 0; gi < N; gi++) begin : g_drv
        assign bus.req_a[32*gi +: 32] = ta[gi];
        assign bus.req_b[32*gi +: 32] = tbv[gi];
    end
    assign bus.req_stb = tstb;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s actual=timeout required=event at %0t", nm, $time);
    endtask

    typedef struct {
        int          id;
        logic [31:0] z;
    } exp_t;
    exp_t sbq[$];

    task automatic push(input int id, input logic [31:0] z);
        exp_t e;
        e.id = id;
        e.z  = z;
        sbq.push_back(e);
    endtask

    // Hand-computed products for every operand pair the bench issues.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {F_2P0, F_3P0}:         return F_6P0;
            {F_1P5, F_1P5}:         return F_2P25;
            {F_2P0, F_0P5}:         return F_1P0;
            {POS_INF, F_2P0}:       return POS_INF;
            {POS_INF, 32'h0}:       return QNAN;
            default:                return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Behavioural multiplier
    int d_ack    = 0;
    int lat      = 3;
    int stb_drop = 0;
    int n_a = 0, n_b = 0, n_z = 0;

    initial begin
        logic [31:0] cap_a, cap_b;
        bit abort;
        int w;
        bus.mul_a_ack = 1'b0;
        bus.mul_b_ack = 1'b0;
        bus.mul_z_stb = 1'b0;
        bus.mul_z     = '0;
        forever begin
            @(negedge clk);
            if (bus.mul_a_stb && !rst) begin
                abort = 1'b0;
                for (int k = 0; k < d_ack; k++) begin
                    @(negedge clk);
                    if (!bus.mul_a_stb) stb_drop++;
                end
                cap_a = bus.mul_a;
                bus.mul_a_ack = 1'b1;
                @(negedge clk);
                bus.mul_a_ack = 1'b0;
                w = 0;
                while (!bus.mul_b_stb && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                for (int k = 0; k < d_ack; k++) begin
                    @(negedge clk);
                    if (!bus.mul_b_stb) stb_drop++;
                end
                cap_b = bus.mul_b;
                bus.mul_b_ack = 1'b1;
                @(negedge clk);
                bus.mul_b_ack = 1'b0;
                for (int k = 0; k < lat; k++) begin
                    @(negedge clk);
                    if (rst) begin
                        abort = 1'b1;
                        break;
                    end
                end
                if (!abort) begin
                    bus.mul_z     = fmul(cap_a, cap_b);
                    bus.mul_z_stb = 1'b1;
                    @(negedge clk);
                    bus.mul_z_stb = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (bus.mul_a_stb && bus.mul_a_ack) n_a++;
        if (bus.mul_b_stb && bus.mul_b_ack) n_b++;
        if (bus.mul_z_stb && bus.mul_z_ack) n_z++;
    end

    // Requester-side accept; junk bits exercise ignored rsp_ack of non-granted requesters.
    initial begin
        bus.rsp_ack = '0;
        forever begin
            @(negedge clk);
            bus.rsp_ack = (bus.rsp_stb & ~hold) | junk;
        end
    end

    // Response monitor
    initial begin
        logic [N-1:0] prev;
        exp_t e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (bus.rsp_stb != '0 && prev == '0) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_rsp actual=stb %b z %h required=no response", bus.rsp_stb, bus.rsp_z);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_stb", 32'(bus.rsp_stb), 32'(1) << e.id);
                    chk("rsp_z", bus.rsp_z, e.z);
                end
            end
            prev = bus.rsp_stb;
        end
    end

    task automatic client_req(input int i, input logic [31:0] a, input logic [31:0] b);
        bit got;
        got = 1'b0;
        @(negedge clk);
        ta[i]   = a;
        tbv[i]  = b;
        tstb[i] = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            if (bus.req_ack[i]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            timeout_fail($sformatf("req_ack_wait_%0d", i));
            tstb[i] = 1'b0;
        end else begin
            chk($sformatf("gnt_id_%0d", i), 32'(gnt_id), 32'(i));
            @(posedge clk);
            #1;
            chk($sformatf("req_ack_pulse_%0d", i), 32'(bus.req_ack), 32'(0));
            tstb[i] = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!busy && bus.rsp_stb == '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("wait_idle");
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req_ack"},   32'(bus.req_ack),   32'(0));
        chk({tag, "_rsp_stb"},   32'(bus.rsp_stb),   32'(0));
        chk({tag, "_rsp_z"},     bus.rsp_z,          32'(0));
        chk({tag, "_mul_a"},     bus.mul_a,          32'(0));
        chk({tag, "_mul_a_stb"}, 32'(bus.mul_a_stb), 32'(0));
        chk({tag, "_mul_b"},     bus.mul_b,          32'(0));
        chk({tag, "_mul_b_stb"}, 32'(bus.mul_b_stb), 32'(0));
        chk({tag, "_mul_z_ack"}, 32'(bus.mul_z_ack), 32'(0));
        chk({tag, "_busy"},      32'(busy),          32'(0));
        chk({tag, "_gnt_id"},    32'(gnt_id),        32'(0));
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int na0, nb0, nz0;
        bit stable, ack3, reached;
        for (int i = 0; i < N; i++) begin
            ta[i]  = '0;
            tbv[i] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single request from requester 1: 2.0 * 3.0
        push(1, F_6P0);
        client_req(1, F_2P0, F_3P0);
        wait_idle();

        // Simultaneous 0 and 2 from reset pointer, then 3 and 0 while 2 is in flight
        pulse_rst();
        push(0, F_2P25);
        push(2, F_1P0);
        fork
            client_req(0, F_1P5, F_1P5);
            client_req(2, F_2P0, F_0P5);
        join
        push(3, F_2P25);
        push(0, F_6P0);
        fork
            client_req(3, F_1P5, F_1P5);
            client_req(0, F_2P0, F_3P0);
        join
        wait_idle();

        // Requester 1 withholds rsp_ack for 20 cycles while requester 3 waits
        hold = 4'b0010;
        junk = 4'b1101;
        push(1, F_6P0);
        client_req(1, F_2P0, F_3P0);
        reached = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.rsp_stb[1]) begin
                reached = 1'b1;
                break;
            end
        end
        if (!reached) timeout_fail("hold_rsp_wait");
        push(3, F_2P25);
        fork
            client_req(3, F_1P5, F_1P5);
        join_none
        stable = 1'b1;
        ack3   = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.rsp_stb != 4'b0010 || bus.rsp_z != F_6P0 || !busy) stable = 1'b0;
            if (bus.req_ack[3]) ack3 = 1'b1;
        end
        chk("hold_stable", 32'(stable), 32'(1));
        chk("hold_no_ack3", 32'(ack3), 32'(0));
        hold = '0;
        junk = '0;
        wait fork;
        wait_idle();

        // Slow operand acks: inf * 2.0 from requester 0
        d_ack = 5;
        na0 = n_a;
        nb0 = n_b;
        nz0 = n_z;
        push(0, POS_INF);
        client_req(0, POS_INF, F_2P0);
        wait_idle();
        chk("slow_a_xfers", 32'(n_a - na0), 32'(1));
        chk("slow_b_xfers", 32'(n_b - nb0), 32'(1));
        chk("slow_z_xfers", 32'(n_z - nz0), 32'(1));
        chk("slow_stb_held", 32'(stb_drop), 32'(0));
        d_ack = 0;

        // inf * 0 gives the quiet NaN from requester 1
        push(1, QNAN);
        client_req(1, POS_INF, 32'h0);
        wait_idle();

        // Reset during WAIT_Z, then pointer restarts at requester 0
        lat = 30;
        client_req(2, F_2P0, F_3P0);
        reached = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.mul_z_ack) begin
                reached = 1'b1;
                break;
            end
        end
        if (!reached) timeout_fail("wait_z_reach");
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero("midrst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        lat = 3;
        push(0, F_2P25);
        push(3, F_6P0);
        fork
            client_req(0, F_1P5, F_1P5);
            client_req(3, F_2P0, F_3P0);
        join
        wait_idle();

`ifdef FP_MUL_ARB_STATS_EN
        @(negedge clk);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push(2, F_1P0);
            client_req(2, F_2P0, F_0P5);
            wait_idle();
        end
        @(negedge clk);
        chk("cnt2_after3", 32'(op_count[2*STAT_W +: STAT_W]), 32'(3));
        chk("cnt0_after3", 32'(op_count[0*STAT_W +: STAT_W]), 32'(0));
        chk("cnt1_after3", 32'(op_count[1*STAT_W +: STAT_W]), 32'(0));
        chk("cnt3_after3", 32'(op_count[3*STAT_W +: STAT_W]), 32'(0));
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        chk("cnt2_cleared", 32'(op_count[2*STAT_W +: STAT_W]), 32'(0));
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
